pin_keypad_entry: RTL

//  Keypad-side PIN transmitter for the parking access gate. Collects BCD digits from a

---
 rtl/pin_keypad_entry_pkg.sv | 15 +
 rtl/pin_keypad_entry_if.sv | 20 ++
 rtl/pin_keypad_entry_timeout.sv | 27 ++
 rtl/pin_keypad_entry.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pin_keypad_entry_pkg.sv
// Shared types and key codes for the keypad PIN entry block.
package pin_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        SEND  = 2'd3
    } entry_state_t;

    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

endpackage

// File: rtl/pin_keypad_entry_if.sv
// Keypad-to-access-controller bus: key strobe in, PIN valid/ack handshake out.
interface pin_keypad_entry_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    clave_ack;
    logic [4*NUM_DIGITS-1:0] clave_ingresada;
    logic                    clave_valida;

    modport master (
        output key_valid, key_code, clave_ack,
        input  clave_ingresada, clave_valida
    );

    modport slave (
        input  key_valid, key_code, clave_ack,
        output clave_ingresada, clave_valida
    );
endinterface

// File: rtl/pin_keypad_entry_timeout.sv
// Idle timer for partial PIN entry; only instantiated when PIN_TIMEOUT_EN is defined.
module pin_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pin_keypad_entry.sv
// Assembles a NUM_DIGITS BCD PIN from keypad strobes and hands it off with valid/ack.
// Optional idle timeout is enabled by defining PIN_TIMEOUT_EN.
module pin_keypad_entry
    import pin_entry_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset,
    pin_keypad_entry_if.slave   bus,
    output logic [2:0]          digit_count,
    output logic                entry_busy,
    output logic                entry_error,
    output logic                entry_timeout
);
    localparam int W = 4 * NUM_DIGITS;
    localparam logic [2:0] ND3 = 3'(NUM_DIGITS);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 7 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("pin_keypad_entry: unsupported NUM_DIGITS or TIMEOUT_CYCLES");
    end

    entry_state_t state, next_state;
    logic [W-1:0] buffer, next_buffer;
    logic [2:0]   next_count;
    logic         next_error, next_timeout;
    logic         is_digit, is_clear, is_enter, is_invalid;
    logic         key_accepted, timer_clear, timer_enable, timer_expire;

    assign is_digit   = bus.key_code <= KEY_DIGIT_MAX;
    assign is_clear   = bus.key_code == KEY_CLEAR;
    assign is_enter   = bus.key_code == KEY_ENTER;
    assign is_invalid = bus.key_code > KEY_ENTER;

    // A digit pressed while FULL is rejected, so it does not count as activity.
    assign key_accepted = bus.key_valid && !is_invalid && !(state == FULL && is_digit);
    assign timer_enable = (state == ENTRY) || (state == FULL);
    assign timer_clear  = key_accepted || !timer_enable;

`ifdef PIN_TIMEOUT_EN
    pin_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .enable(timer_enable),
        .expire(timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        next_buffer  = buffer;
        next_count   = digit_count;
        next_error   = 1'b0;
        next_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        next_buffer = {buffer[W-5:0], bus.key_code};
                        next_count  = 3'd1;
                        next_state  = ENTRY;
                    end else if (is_enter || is_invalid) begin
                        next_error = 1'b1;
                    end
                end
            end
            ENTRY, FULL: begin
                if (bus.key_valid && is_invalid) begin
                    next_error = 1'b1;
                end else if (bus.key_valid && is_digit && state == FULL) begin
                    next_error = 1'b1;
                end
                if (key_accepted) begin
                    if (is_digit) begin
                        next_buffer = {buffer[W-5:0], bus.key_code};
                        next_count  = digit_count + 3'd1;
                        if (next_count == ND3) begin
                            next_state = FULL;
                        end
                    end else if (is_enter && state == FULL) begin
                        next_state = SEND;
                    end else begin
                        // CLEAR, or ENTER on a short entry, discards everything.
                        next_error  = is_enter;
                        next_buffer = '0;
                        next_count  = 3'd0;
                        next_state  = IDLE;
                    end
                end else if (timer_expire) begin
                    next_buffer  = '0;
                    next_count   = 3'd0;
                    next_state   = IDLE;
                    next_timeout = 1'b1;
                end
            end
            SEND: begin
                if (bus.clave_ack) begin
                    next_buffer = '0;
                    next_count  = 3'd0;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            buffer           <= '0;
            digit_count      <= 3'd0;
            bus.clave_valida <= 1'b0;
            entry_busy       <= 1'b0;
            entry_error      <= 1'b0;
            entry_timeout    <= 1'b0;
        end else begin
            state            <= next_state;
            buffer           <= next_buffer;
            digit_count      <= next_count;
            bus.clave_valida <= (next_state == SEND);
            entry_busy       <= (next_state == SEND);
            entry_error      <= next_error;
            entry_timeout    <= next_timeout;
        end
    end

    assign bus.clave_ingresada = buffer;
endmodule
